// File: rtl/bet_ledger_if.sv
// bet_ledger_if: connects the keystroke side (PS/2 decoder, Arduino chip
// sensor, payout processor) to the bet ledger and carries the ledger
// contents back to the register file.
//
// Signals:
//   key_valid    keystroke-valid level from the PS/2 controller
//   key_opcode   decoded bet opcode (OPCODE_W bits)
//   color        chip colour, 3'b000 means no chip on the sensor
//   payout_done  one-cycle pulse when the processor finishes the payout pass
//   bets_flat    DEPTH packed entries, entry i at [i*ENTRY_W +: ENTRY_W]
//   bet_count    number of valid entries
//   full         bet_count == DEPTH
//   locked       ledger frozen for payout
//   spin_req     one-cycle pulse when a spin is accepted
//   rejected     one-cycle pulse when a keystroke is discarded
//
// Modports: master drives the keystroke side, slave is the ledger itself.
interface bet_ledger_if #(
    parameter int DEPTH    = 12,
    parameter int OPCODE_W = 6,
    parameter int COLOR_W  = 2
);
    localparam int ENTRY_W = COLOR_W + OPCODE_W;

    logic                       key_valid;
    logic [OPCODE_W-1:0]        key_opcode;
    logic [2:0]                 color;
    logic                       payout_done;
    logic [DEPTH*ENTRY_W-1:0]   bets_flat;
    logic [5:0]                 bet_count;
    logic                       full;
    logic                       locked;
    logic                       spin_req;
    logic                       rejected;

    modport master (
        output key_valid, key_opcode, color, payout_done,
        input  bets_flat, bet_count, full, locked, spin_req, rejected
    );

    modport slave (
        input  key_valid, key_opcode, color, payout_done,
        output bets_flat, bet_count, full, locked, spin_req, rejected
    );
endinterface

// File: rtl/bet_ledger.sv
// bet_ledger: bet capture buffer between the PS/2 keystroke decoder and the
// register file. Each rising edge of key_valid is one keystroke event; a
// valid bet is stored as {color[COLOR_W-1:0], opcode} in the next free entry.
// CLEAR_OP empties the ledger, SPIN_OP (with at least one bet) freezes it in
// LOCKED until the processor pulses payout_done, which empties it again.
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-low reset
//   bus    bet_ledger_if slave modport (keystroke inputs, ledger outputs)
module bet_ledger #(
    parameter int                  DEPTH    = 12,
    parameter int                  OPCODE_W = 6,
    parameter int                  COLOR_W  = 2,
    parameter logic [OPCODE_W-1:0] SPIN_OP  = 6'b111110,
    parameter logic [OPCODE_W-1:0] CLEAR_OP = 6'b111111
) (
    input logic         clock,
    input logic         reset,
    bet_ledger_if.slave bus
);
    localparam int         ENTRY_W = COLOR_W + OPCODE_W;
    localparam logic [5:0] DEPTH_C = 6'(DEPTH);

    typedef enum logic {
        COLLECT,
        LOCKED
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                key_valid_q;
    logic [5:0]          bet_count;
    logic [5:0]          count_next;
    logic [ENTRY_W-1:0]  entries [DEPTH];
    logic                full_q;
    logic                spin_q;
    logic                rejected_q;
    logic                key_event;
    logic                clear_all;
    logic                write_en;
    logic                spin_next;
    logic                rejected_next;
    logic [ENTRY_W-1:0]  new_entry;

    // key_valid_q resets high so a key held through reset release is not
    // mistaken for a fresh keystroke.
    assign key_event = bus.key_valid & ~key_valid_q;

    // Colour bits above COLOR_W only matter for the no-chip test.
    assign new_entry = {bus.color[COLOR_W-1:0], bus.key_opcode};

    // Next-state and event decode. In LOCKED every keystroke is rejected,
    // and payout_done takes priority over a simultaneous keystroke.
    always_comb begin
        state_next    = state;
        count_next    = bet_count;
        clear_all     = 1'b0;
        write_en      = 1'b0;
        spin_next     = 1'b0;
        rejected_next = 1'b0;
        case (state)
            COLLECT: begin
                if (key_event) begin
                    if (bus.key_opcode == CLEAR_OP) begin
                        clear_all  = 1'b1;
                        count_next = '0;
                    end else if (bus.key_opcode == SPIN_OP) begin
                        if (bet_count != 6'd0) begin
                            state_next = LOCKED;
                            spin_next  = 1'b1;
                        end else begin
                            rejected_next = 1'b1;
                        end
                    end else if (bus.color == 3'b000) begin
                        rejected_next = 1'b1;
                    end else if (bet_count == DEPTH_C) begin
                        rejected_next = 1'b1;
                    end else begin
                        write_en   = 1'b1;
                        count_next = bet_count + 6'd1;
                    end
                end
            end
            LOCKED: begin
                rejected_next = key_event;
                if (bus.payout_done) begin
                    clear_all  = 1'b1;
                    count_next = '0;
                    state_next = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= COLLECT;
            bet_count   <= '0;
            full_q      <= 1'b0;
            spin_q      <= 1'b0;
            rejected_q  <= 1'b0;
            key_valid_q <= 1'b1;
        end else begin
            state       <= state_next;
            bet_count   <= count_next;
            full_q      <= (count_next == DEPTH_C);
            spin_q      <= spin_next;
            rejected_q  <= rejected_next;
            key_valid_q <= bus.key_valid;
        end
    end

    // Entries are written only at the slot addressed by bet_count, so slots
    // beyond the count stay at zero until written.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset || clear_all) begin
                entries[i] <= '0;
            end else if (write_en && (bet_count == 6'(i))) begin
                entries[i] <= new_entry;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign bus.bets_flat[g*ENTRY_W +: ENTRY_W] = entries[g];
    end

    assign bus.bet_count = bet_count;
    assign bus.full      = full_q;
    assign bus.locked    = (state == LOCKED);
    assign bus.spin_req  = spin_q;
    assign bus.rejected  = rejected_q;
endmodule

// File: tb/tb_bet_ledger.sv
// tb_bet_ledger: directed bench for bet_ledger. One instance uses the default
// parameters (DEPTH=12, COLOR_W=2), a second uses DEPTH=4, COLOR_W=3 so the
// 9-bit entry layout is exercised. Inputs change on the falling edge and
// outputs are compared on the following falling edge.
module tb_bet_ledger;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    bet_ledger_if #(.DEPTH(12), .OPCODE_W(6), .COLOR_W(2)) bus_a ();
    bet_ledger_if #(.DEPTH(4),  .OPCODE_W(6), .COLOR_W(3)) bus_b ();

    bet_ledger dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    bet_ledger #(.DEPTH(4), .COLOR_W(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        string      tag;
        bit         unit_b;
        logic [5:0] count;
        logic       spin;
        logic       rej;
        logic       lock;
        logic       full;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(string tag, logic [95:0] obs, logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(bit unit_b, logic valid, logic [5:0] op,
                                 logic [2:0] col, logic payout);
        if (unit_b) begin
            bus_b.key_valid   = valid;
            bus_b.key_opcode  = op;
            bus_b.color       = col;
            bus_b.payout_done = payout;
        end else begin
            bus_a.key_valid   = valid;
            bus_a.key_opcode  = op;
            bus_a.color       = col;
            bus_a.payout_done = payout;
        end
    endtask

    task automatic push_expect(string tag, bit unit_b, logic [5:0] count,
                               logic spin, logic rej, logic lock, logic full);
        exp_t e;
        e.tag    = tag;
        e.unit_b = unit_b;
        e.count  = count;
        e.spin   = spin;
        e.rej    = rej;
        e.lock   = lock;
        e.full   = full;
        sb.push_back(e);
    endtask

    // Advance one cycle and compare the oldest scoreboard entry.
    task automatic checkOutput();
        exp_t e;
        @(negedge clock);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            if (e.unit_b) begin
                check_val({e.tag, ".count"}, bus_b.bet_count, e.count);
                check_val({e.tag, ".spin"},  bus_b.spin_req,  e.spin);
                check_val({e.tag, ".rej"},   bus_b.rejected,  e.rej);
                check_val({e.tag, ".lock"},  bus_b.locked,    e.lock);
                check_val({e.tag, ".full"},  bus_b.full,      e.full);
            end else begin
                check_val({e.tag, ".count"}, bus_a.bet_count, e.count);
                check_val({e.tag, ".spin"},  bus_a.spin_req,  e.spin);
                check_val({e.tag, ".rej"},   bus_a.rejected,  e.rej);
                check_val({e.tag, ".lock"},  bus_a.locked,    e.lock);
                check_val({e.tag, ".full"},  bus_a.full,      e.full);
            end
        end
    endtask

    // One keystroke: key_valid high for a cycle, then low for a cycle. The
    // second check confirms spin_req/rejected last exactly one cycle.
    task automatic pulse(string tag, bit unit_b, logic [5:0] op, logic [2:0] col,
                         logic [5:0] count, logic spin, logic rej, logic lock,
                         logic full);
        applyStimulus(unit_b, 1'b1, op, col, 1'b0);
        push_expect(tag, unit_b, count, spin, rej, lock, full);
        checkOutput();
        applyStimulus(unit_b, 1'b0, op, col, 1'b0);
        push_expect({tag, "_after"}, unit_b, count, 1'b0, 1'b0, lock, full);
        checkOutput();
    endtask

    function automatic logic [7:0] entry_a(int idx);
        return bus_a.bets_flat[idx*8 +: 8];
    endfunction

    function automatic logic [8:0] entry_b(int idx);
        return bus_b.bets_flat[idx*9 +: 9];
    endfunction

    initial begin
        $display("[TB] start");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 6'h05, 3'b001, 1'b0);
        applyStimulus(1'b1, 1'b1, 6'h05, 3'b001, 1'b0);
        repeat (2) @(negedge clock);

        // Reset state with key_valid held high.
        push_expect("reset_a", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        push_expect("reset_b", 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        check_val("reset_flat_a", bus_a.bets_flat, 96'h0);

        // Release reset with key_valid still high: no event may be seen.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_expect($sformatf("held_valid%0d", i), 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput();
        end
        check_val("held_valid_flat", bus_a.bets_flat, 96'h0);
        applyStimulus(1'b0, 1'b0, 6'h05, 3'b001, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'h05, 3'b001, 1'b0);
        push_expect("held_valid_drop", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();

        // Two bets and a no-chip keystroke.
        pulse("bet0",   1'b0, 6'h05, 3'b001, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse("bet1",   1'b0, 6'h12, 3'b010, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse("nochip", 1'b0, 6'h05, 3'b000, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("entry0", entry_a(0), 8'h45);
        check_val("entry1", entry_a(1), 8'h92);
        check_val("entry2", entry_a(2), 8'h00);

        pulse("clear1", 1'b0, 6'h3F, 3'b001, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("clear1_flat", bus_a.bets_flat, 96'h0);

        // Fourteen bets into a 12-deep ledger.
        for (int i = 0; i < 14; i++) begin
            pulse($sformatf("fill%0d", i), 1'b0, 6'(i + 1), 3'((i % 3) + 1),
                  (i < 12) ? 6'(i + 1) : 6'd12, 1'b0, (i >= 12), 1'b0, (i >= 11));
        end
        check_val("fill_entry0",  entry_a(0),  8'h41);
        check_val("fill_entry11", entry_a(11), 8'hCC);

        pulse("clear_full", 1'b0, 6'h3F, 3'b001, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("clear_full_flat", bus_a.bets_flat, 96'h0);

        // Spin handling and the locked state.
        pulse("spin_empty",   1'b0, 6'h3E, 3'b001, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse("bet_pre_spin", 1'b0, 6'h07, 3'b010, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse("spin",         1'b0, 6'h3E, 3'b001, 6'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        pulse("bet_locked",   1'b0, 6'h08, 3'b001, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        pulse("clear_locked", 1'b0, 6'h3F, 3'b001, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        pulse("spin_locked",  1'b0, 6'h3E, 3'b001, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("locked_entry0", entry_a(0), 8'h87);

        // payout_done together with a keystroke edge.
        applyStimulus(1'b0, 1'b1, 6'h0A, 3'b001, 1'b1);
        push_expect("payout_edge", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput();
        check_val("payout_edge_flat", bus_a.bets_flat, 96'h0);
        applyStimulus(1'b0, 1'b0, 6'h0A, 3'b001, 1'b0);
        push_expect("payout_edge_after", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();

        pulse("bet_after_payout", 1'b0, 6'h09, 3'b011, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("after_payout_entry0", entry_a(0), 8'hC9);

        // Colour 3'b100 carries a chip but stores colour bits 2'b00.
        pulse("bet_hicolor", 1'b0, 6'h0B, 3'b100, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse("bet_c",       1'b0, 6'h0C, 3'b010, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse("bet_d",       1'b0, 6'h0D, 3'b011, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("hicolor_entry1", entry_a(1), 8'h0B);
        check_val("bet_d_entry3",   entry_a(3), 8'hCD);

        // payout_done while collecting is ignored.
        applyStimulus(1'b0, 1'b0, 6'h0D, 3'b011, 1'b1);
        push_expect("payout_collect", 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 6'h0D, 3'b011, 1'b0);
        check_val("payout_collect_entry3", entry_a(3), 8'hCD);

        pulse("clear_four", 1'b0, 6'h3F, 3'b001, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("clear_four_flat", bus_a.bets_flat, 96'h0);

        // Reset while locked, with a keystroke edge arriving at the same time.
        pulse("bet_r",  1'b0, 6'h01, 3'b001, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse("spin_r", 1'b0, 6'h3E, 3'b001, 6'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 6'h02, 3'b001, 1'b0);
        push_expect("reset_locked", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        reset = 1'b1;
        push_expect("reset_release", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        check_val("reset_locked_flat", bus_a.bets_flat, 96'h0);
        applyStimulus(1'b0, 1'b0, 6'h02, 3'b001, 1'b0);
        push_expect("reset_release_drop", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();

        // DEPTH=4, COLOR_W=3 instance: five bets, 9-bit entries.
        for (int i = 0; i < 5; i++) begin
            pulse($sformatf("b_fill%0d", i), 1'b1, 6'(i + 1), 3'b101,
                  (i < 4) ? 6'(i + 1) : 6'd4, 1'b0, (i == 4), 1'b0, (i >= 3));
        end
        check_val("b_entry0", entry_b(0), 9'h141);
        check_val("b_entry3", entry_b(3), 9'h144);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bet_ledger.md
# bet_ledger

Parametrised bet capture buffer between the PS/2 keystroke decoder and the register file. It records one bet per keystroke as {chip colour, bet opcode} and rejects keystrokes that carry no chip or target a control opcode. A spin keystroke freezes the ledger for the processor's payout pass, and a payout-done pulse clears it. It generalises the fixed twelve-register, every-other-count latch: depth and field widths are parameters, capture is edge-based, and it adds a full flag, a clear command, rejection reporting and a locked state.

## Interface
- DEPTH, 12, number of bet entries (2..63)
- OPCODE_W, 6, bet opcode width
- COLOR_W, 2, chip colour field stored per entry
- SPIN_OP, 6'b111110, opcode that requests a spin
- CLEAR_OP, 6'b111111, opcode that empties the ledger
- ENTRY_W, COLOR_W+OPCODE_W, derived entry width; not overridden

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- key_valid  in  1  keystroke-valid level from the PS/2 controller
- key_opcode  in  OPCODE_W  decoded bet opcode
- color  in  3  chip colour from the Arduino; 3'b000 means no chip
- payout_done  in  1  single-cycle pulse from the processor when payout has been computed
- bets_flat  out  DEPTH*ENTRY_W  entry i occupies bits [i*ENTRY_W +: ENTRY_W]; each entry is {color[COLOR_W-1:0], opcode}
- bet_count  out  6  number of valid entries
- full  out  1  bet_count == DEPTH
- locked  out  1  high while in the LOCKED state
- spin_req  out  1  one-cycle pulse when a spin is accepted
- rejected  out  1  one-cycle pulse when a keystroke edge is discarded

## Operation
- Keystroke event: a rising edge of key_valid, detected as key_valid & ~key_valid_q. key_valid_q resets to 1, so a key_valid level held high through reset release produces no event.
- State COLLECT handles each event in this priority order:
  - opcode == CLEAR_OP: all entries and bet_count go to 0. Not counted as a rejection.
  - opcode == SPIN_OP and bet_count > 0: go to LOCKED and pulse spin_req.
  - opcode == SPIN_OP and bet_count == 0: pulse rejected; stay in COLLECT.
  - color == 0: pulse rejected.
  - full: pulse rejected; entries unchanged.
  - otherwise: write entry[bet_count] and increment bet_count.
- State LOCKED:
  - Every event pulses rejected, including CLEAR_OP and SPIN_OP.
  - payout_done clears all entries, sets bet_count to 0 and returns to COLLECT.
- Entry stored value is {color[COLOR_W-1:0], key_opcode}. Colour bits above COLOR_W are used only for the no-chip check.
- Unused entries always read 0. bet_count never exceeds DEPTH and never wraps.
- payout_done while in COLLECT is ignored.

## Timing
- Reset (reset == 0 at a clock edge) forces:
  - state = COLLECT
  - all entries = 0, bet_count = 0
  - full = 0, locked = 0, spin_req = 0, rejected = 0
  - key_valid_q = 1
- Reset mid-LOCKED or mid-keystroke discards everything; no spin_req or rejected pulse is issued.
- Event latency is 1 cycle. An event sampled at edge N updates entries, bet_count, full and locked, and pulses spin_req or rejected, all visible after edge N. Every output is registered.
- spin_req and rejected are exactly one cycle wide per event. At most one event occurs per key_valid rising edge, regardless of how long key_valid stays high.
- Simultaneous payout_done and event in LOCKED: payout_done wins, the event is discarded, and rejected pulses.
- Events on consecutive cycles need key_valid to fall and rise again. Each is handled independently at 1-cycle latency.

## Test plan
- Default parameters, reset released with key_valid=1: no entry written, and bet_count=0 after 5 cycles.
- Three pulses (opcode 6'h05 color 3'b001; 6'h12 color 3'b010; 6'h05 color 3'b000) -> entry0=8'h45, entry1=8'h92, bet_count=2, one rejected pulse on the third.
- Fourteen valid pulses with DEPTH=12 -> full=1 after the 12th, bet_count stays 12, rejected pulses on the 13th and 14th, entry11 holds the 12th bet.
- SPIN_OP with bet_count=0 -> rejected. Add one bet, then SPIN_OP -> spin_req for one cycle, locked=1. A further bet pulse -> rejected, bet_count still 1.
- payout_done and a key edge in the same cycle while locked -> locked=0, bet_count=0, all entries 0, rejected=1. The next valid bet lands in entry0.
- Four bets then CLEAR_OP -> bet_count=0, bets_flat all zero, no rejected pulse. DEPTH=4 and COLOR_W=3 rerun -> full after 4 bets, entry width 9 bits.
